// File: rtl/mux_pkg.sv
// Shared definitions for the mux_arb channel selector.
// Holds the mode encodings and a clog2 helper used for default index widths.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority finder: returns the first requester at or above ptr,
// wrapping CH-1 -> 0. This also works when CH is not a power of two.
module mux_rr_pick
    import mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int SEL_W = clog2(CH)
) (
    input  logic [CH-1:0]    req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    localparam logic [SEL_W:0] CH_W = (SEL_W + 1)'(CH);

    logic [SEL_W-1:0] cand_idx [CH];
    logic [CH-1:0]    cand_req;

    // Candidate gi is the channel gi positions after ptr in wrap order.
    for (genvar gi = 0; gi < CH; gi++) begin : g_cand
        logic [SEL_W:0] sum;
        assign sum          = {1'b0, ptr} + (SEL_W + 1)'(gi);
        assign cand_idx[gi] = (sum >= CH_W) ? SEL_W'(sum - CH_W) : SEL_W'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N-channel selector with a registered, handshaked output slot.
// The channel is chosen either by a fixed option code or by round-robin arbitration.
module mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEL_W = clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] din,
    input  logic [CH-1:0]       din_valid,
    output logic [CH-1:0]       din_ready,
    input  logic                mode,
    input  logic [SEL_W-1:0]    option,
    output logic [WIDTH-1:0]    dout,
    output logic [SEL_W-1:0]    dout_ch,
    output logic                dout_valid,
    input  logic                dout_ready
);

    logic [WIDTH-1:0] dout_q,       dout_d;
    logic [SEL_W-1:0] dout_ch_q,    dout_ch_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SEL_W-1:0] ptr_q,        ptr_d;

    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [CH-1:0]    sel_oh;
    logic             fixed_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;

    mux_rr_pick #(
        .CH    (CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (din_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // An option code of CH or above matches no bit, so it can never grant.
    for (genvar gi = 0; gi < CH; gi++) begin : g_sel
        assign sel_oh[gi] = (option == SEL_W'(gi));
    end
    assign fixed_any = |(din_valid & sel_oh);

    assign gnt_idx  = (mode == MODE_RR) ? rr_idx : option;
    assign gnt_any  = (mode == MODE_RR) ? rr_any : fixed_any;
    assign can_load = !dout_valid_q || dout_ready;
    assign xfer     = gnt_any && can_load && !rst;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ready
        assign din_ready[gi] = xfer && (gnt_idx == SEL_W'(gi));
    end

    always_comb begin
        gnt_data = '0;
        for (int j = 0; j < CH; j++) begin
            if (gnt_idx == SEL_W'(j)) begin
                gnt_data = din[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        ptr_d        = ptr_q;
        if (xfer) begin
            dout_d       = gnt_data;
            dout_ch_d    = gnt_idx;
            dout_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (gnt_idx == SEL_W'(CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            ptr_q        <= ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: directed tables for CH=4 and CH=3, plus randomized
// CH=4 traffic checked against a queue-free arithmetic reference model.
module tb_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, mode4, dr4, dv4;
    logic [31:0] din4;
    logic [3:0]  valid4, ready4;
    logic [1:0]  opt4, ch4;
    logic [7:0]  dout4;

    logic        rst3, mode3, dr3, dv3;
    logic [23:0] din3;
    logic [2:0]  valid3, ready3;
    logic [1:0]  opt3, ch3;
    logic [7:0]  dout3;

    mux_arb #(.WIDTH(8), .CH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .din(din4), .din_valid(valid4), .din_ready(ready4),
        .mode(mode4), .option(opt4), .dout(dout4), .dout_ch(ch4),
        .dout_valid(dv4), .dout_ready(dr4)
    );

    mux_arb #(.WIDTH(8), .CH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .din(din3), .din_valid(valid3), .din_ready(ready3),
        .mode(mode3), .option(opt3), .dout(dout3), .dout_ch(ch3),
        .dout_valid(dv3), .dout_ready(dr3)
    );

    typedef struct {
        bit        rst;
        bit        mode;
        bit [1:0]  opt;
        bit [3:0]  valid;
        bit [31:0] din;
        bit        dr;
        bit [3:0]  e_rdy;
        bit [7:0]  e_d;
        bit [1:0]  e_c;
        bit        e_v;
    } row_t;

    row_t tab4 [24];
    row_t tab3 [10];

    int checks   = 0;
    int failures = 0;

    // Reference model state for the CH=4 instance
    bit       m_v = 1'b0;
    bit [7:0] m_d = 8'h00;
    int       m_c = 0;
    int       m_p = 0;

    function automatic row_t mk(bit rst, bit mode, bit [1:0] opt, bit [3:0] valid,
                                bit [31:0] din, bit dr, bit [3:0] e_rdy,
                                bit [7:0] e_d, bit [1:0] e_c, bit e_v);
        row_t r;
        r.rst = rst; r.mode = mode; r.opt = opt; r.valid = valid; r.din = din;
        r.dr = dr; r.e_rdy = e_rdy; r.e_d = e_d; r.e_c = e_c; r.e_v = e_v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Grant by the rules: fixed picks option if valid; RR takes the first valid
    // channel counting upward from the pointer modulo 4.
    task automatic model_grant(output bit any, output int g);
        any = 1'b0;
        g   = 0;
        if (rst4) begin
            any = 1'b0;
        end else if (mode4 == 1'b0) begin
            g   = int'(opt4);
            any = valid4[opt4];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_p + k) % 4;
                if (!any && valid4[i]) begin
                    any = 1'b1;
                    g   = i;
                end
            end
        end
    endtask

    task automatic run4(input row_t r, input int idx, input bit use_tab);
        bit       any, xfer;
        int       g;
        bit [3:0] exp_rdy;
        rst4 = r.rst; mode4 = r.mode; opt4 = r.opt; valid4 = r.valid;
        din4 = r.din; dr4 = r.dr;
        model_grant(any, g);
        xfer    = any && (!m_v || dr4);
        exp_rdy = xfer ? 4'(1 << g) : 4'b0000;
        @(negedge clk);
        chk("ch4_din_ready", 32'(ready4), use_tab ? 32'(r.e_rdy) : 32'(exp_rdy));
        @(posedge clk);
        if (rst4) begin
            m_v = 1'b0; m_d = 8'h00; m_c = 0; m_p = 0;
        end else if (xfer) begin
            m_d = 8'(din4 >> (8 * g));
            m_c = g;
            m_v = 1'b1;
            if (mode4) m_p = (g + 1) % 4;
        end else if (dr4) begin
            m_v = 1'b0;
        end
        #1;
        chk("ch4_dout",       32'(dout4), use_tab ? 32'(r.e_d) : 32'(m_d));
        chk("ch4_dout_ch",    32'(ch4),   use_tab ? 32'(r.e_c) : 32'(m_c));
        chk("ch4_dout_valid", 32'(dv4),   use_tab ? 32'(r.e_v) : 32'(m_v));
        $display("dut4 %s %0d: rdy=%b dout=%h ch=%0d v=%b",
                 use_tab ? "row" : "rnd", idx, ready4, dout4, ch4, dv4);
    endtask

    task automatic run3(input row_t r, input int idx);
        rst3 = r.rst; mode3 = r.mode; opt3 = r.opt; valid3 = r.valid[2:0];
        din3 = r.din[23:0]; dr3 = r.dr;
        @(negedge clk);
        chk("ch3_din_ready", 32'(ready3), 32'(r.e_rdy));
        @(posedge clk);
        #1;
        chk("ch3_dout",       32'(dout3), 32'(r.e_d));
        chk("ch3_dout_ch",    32'(ch3),   32'(r.e_c));
        chk("ch3_dout_valid", 32'(dv3),   32'(r.e_v));
        $display("dut3 row %0d: rdy=%b dout=%h ch=%0d v=%b", idx, ready3, dout3, ch3, dv3);
    endtask

    initial begin
        row_t r;
        rst4 = 1'b1; mode4 = 1'b0; opt4 = '0; valid4 = '0; din4 = '0; dr4 = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; opt3 = '0; valid3 = '0; din3 = '0; dr3 = 1'b0;

        //              rst mode opt valid     din            dr  e_rdy    e_d    e_c e_v
        tab4[0]  = mk(1, 0, 0, 4'b0000, 32'h00000000, 0, 4'b0000, 8'h00, 0, 0);
        tab4[1]  = mk(0, 0, 2, 4'b0100, 32'h00A50000, 1, 4'b0100, 8'hA5, 2, 1);
        tab4[2]  = mk(0, 0, 2, 4'b0000, 32'h00A50000, 1, 4'b0000, 8'hA5, 2, 0);
        tab4[3]  = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0001, 8'h11, 0, 1);
        tab4[4]  = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0010, 8'h22, 1, 1);
        tab4[5]  = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0100, 8'h33, 2, 1);
        tab4[6]  = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b1000, 8'h44, 3, 1);
        tab4[7]  = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0001, 8'h11, 0, 1);
        tab4[8]  = mk(0, 1, 0, 4'b0010, 32'h00331100, 1, 4'b0010, 8'h11, 1, 1);
        tab4[9]  = mk(0, 1, 0, 4'b0100, 32'h00331100, 0, 4'b0000, 8'h11, 1, 1);
        tab4[10] = mk(0, 1, 0, 4'b0100, 32'h00331100, 0, 4'b0000, 8'h11, 1, 1);
        tab4[11] = mk(0, 1, 0, 4'b0100, 32'h00331100, 0, 4'b0000, 8'h11, 1, 1);
        tab4[12] = mk(0, 1, 0, 4'b0100, 32'h00331100, 1, 4'b0100, 8'h33, 2, 1);
        tab4[13] = mk(0, 1, 0, 4'b0001, 32'h00331100, 1, 4'b0001, 8'h00, 0, 1);
        tab4[14] = mk(0, 1, 0, 4'b0010, 32'h00331100, 1, 4'b0010, 8'h11, 1, 1);
        tab4[15] = mk(0, 1, 0, 4'b0001, 32'h00331100, 1, 4'b0001, 8'h00, 0, 1);
        tab4[16] = mk(0, 1, 0, 4'b0100, 32'h00331100, 1, 4'b0100, 8'h33, 2, 1);
        tab4[17] = mk(0, 0, 0, 4'b1111, 32'h44332211, 1, 4'b0001, 8'h11, 0, 1);
        tab4[18] = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b1000, 8'h44, 3, 1);
        tab4[19] = mk(1, 1, 0, 4'b1111, 32'h44332211, 0, 4'b0000, 8'h00, 0, 0);
        tab4[20] = mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0001, 8'h11, 0, 1);
        tab4[21] = mk(0, 0, 3, 4'b0111, 32'h44332211, 1, 4'b0000, 8'h11, 0, 0);
        tab4[22] = mk(0, 0, 1, 4'b0010, 32'h44332211, 0, 4'b0010, 8'h22, 1, 1);
        tab4[23] = mk(0, 0, 1, 4'b0010, 32'h44332211, 0, 4'b0000, 8'h22, 1, 1);

        tab3[0] = mk(1, 0, 0, 4'b0000, 32'h00CCBBAA, 0, 4'b0000, 8'h00, 0, 0);
        tab3[1] = mk(0, 1, 0, 4'b0010, 32'h00CCBBAA, 1, 4'b0010, 8'hBB, 1, 1);
        tab3[2] = mk(0, 1, 0, 4'b0011, 32'h00CCBBAA, 1, 4'b0001, 8'hAA, 0, 1);
        tab3[3] = mk(0, 0, 3, 4'b0111, 32'h00CCBBAA, 0, 4'b0000, 8'hAA, 0, 1);
        tab3[4] = mk(0, 0, 3, 4'b0111, 32'h00CCBBAA, 1, 4'b0000, 8'hAA, 0, 0);
        tab3[5] = mk(0, 0, 3, 4'b0111, 32'h00CCBBAA, 1, 4'b0000, 8'hAA, 0, 0);
        tab3[6] = mk(0, 0, 2, 4'b0111, 32'h00CCBBAA, 1, 4'b0100, 8'hCC, 2, 1);
        tab3[7] = mk(0, 1, 0, 4'b0111, 32'h00CCBBAA, 1, 4'b0010, 8'hBB, 1, 1);
        tab3[8] = mk(0, 1, 0, 4'b0111, 32'h00CCBBAA, 1, 4'b0100, 8'hCC, 2, 1);
        tab3[9] = mk(0, 1, 0, 4'b0111, 32'h00CCBBAA, 1, 4'b0001, 8'hAA, 0, 1);

        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            run4(tab4[i], i, 1'b1);
        end

        for (int i = 0; i < 300; i++) begin
            r = mk(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom),
                   4'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                   4'b0000, 8'h00, 0, 0);
            run4(r, i, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            run3(tab3[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
